// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: parses a length-prefixed little-endian byte
// stream, writes one word per index from 0, and releases the core on a good checksum.
module imem_loader #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data,
  output logic              cpu_rst_n,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]  word_cnt_q, word_cnt_d;
  logic [31:0]        len_q, len_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [7:0]         chk_q, chk_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [WIDTH-1:0]   wr_data_q, wr_data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               cpu_rst_n_q, cpu_rst_n_d;
  logic               accept;
  logic [31:0]        n_full;

  assign rx_ready  = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CHK);
  assign accept    = rx_valid && rx_ready;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cpu_rst_n = cpu_rst_n_q;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    len_d      = len_q;
    word_d     = word_q;
    chk_d      = chk_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    // Bytes arrive LSB first, so shifting in from the top leaves them in place.
    n_full     = {rx_data, len_q[31:8]};

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          len_d      = '0;
          chk_d      = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          chk_d      = chk_q ^ rx_data;
          len_d      = n_full;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (n_full > 32'(DEPTH))  state_d = S_ERR;
            else if (n_full == '0)    state_d = S_CHK;
            else                      state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          chk_d      = chk_q ^ rx_data;
          word_d     = {rx_data, word_q[WIDTH-1:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d   = S_WRITE;
            wr_addr_d = word_cnt_q;
            wr_data_d = word_d;
          end
        end
      end
      S_WRITE: begin
        if (32'(word_cnt_q) == len_q - 32'd1) begin
          state_d = S_CHK;
        end else begin
          word_cnt_d = word_cnt_q + ADDR_W'(1);
          state_d    = S_DATA;
        end
      end
      S_CHK: begin
        if (accept) state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    wr_en_d     = (state_d == S_WRITE);
    done_d      = (state_d == S_DONE);
    err_d       = (state_d == S_ERR);
    cpu_rst_n_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      len_q       <= '0;
      word_q      <= '0;
      chk_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      len_q       <= len_d;
      word_q      <= word_d;
      chk_q       <= chk_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

endmodule
